spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Command decoder and configuration-register controller sitting directly behind the SPI serial-to-parallel front end. It consumes completed bytes, interprets the first byte of each frame as a command (read/write plus start address) and following bytes as data, and writes an array of 8-bit configuration registers with address auto-increment. Frame boundaries come from the SPI clock-stop detector's active-low frame reset, which re-arms the controller for a new command.

## Interface
- NUM_REGS, 16, number of 8-bit config registers (1..128)
- RESET_VAL, 8'h00, reset value of every register
- sclk  in  1  SPI clock; all state on posedge
- rstn  in  1  asynchronous, active-low, full reset
- frame_rstn  in  1  asynchronous, active-low frame abort from clock-stop detector; resets FSM/address only, never registers
- byte_in  in  8  completed byte from serial-to-parallel block
- byte_valid  in  1  one-sclk-cycle qualifier for byte_in
- regs  out  NUM_REGS*8  flattened register array, reg k at [8k+7:8k]
- wr_strobe  out  1  one-cycle pulse when a register is written
- wr_addr  out  7  address of last write
- err  out  1  sticky: write/read address ran past NUM_REGS-1
- miso  out  1  readback serial data (only with SPI_REG_READBACK_EN; else tied 0)

## Operation
- Command byte: bit7 = 1 write, 0 read; bits 6:0 = start address.
- FSM states: CMD, WDATA, RDATA, IGNORE.
- CMD + byte_valid: write with addr < NUM_REGS → WDATA, addr ← bits6:0; read with addr < NUM_REGS → RDATA (IGNORE if readback compiled out, no err); addr ≥ NUM_REGS → err ← 1, IGNORE.
- WDATA + byte_valid: regs[addr] ← byte_in, wr_strobe pulse, wr_addr ← addr; addr ← addr+1. If written addr was NUM_REGS-1 → IGNORE, err ← 1 only if a further byte arrives in IGNORE during this frame.
- RDATA + byte_valid: incoming byte is dummy, discarded; addr ← addr+1; same wrap rule as WDATA.
- IGNORE: all bytes discarded until frame_rstn low.
- frame_rstn low: state ← CMD, addr ← 0, readback shifter cleared; regs, err, wr_addr held.
- byte_valid sampled low or frame_rstn low at the same edge: byte ignored.
- No address wrap-around; arithmetic on 7-bit addr, compared against NUM_REGS before write.

## Timing
- Reset (rstn): regs = RESET_VAL, wr_strobe 0, wr_addr 0, err 0, miso 0, state CMD.
- Write latency: regs and wr_addr update at the sclk edge sampling byte_valid; wr_strobe high for exactly the following cycle.
- err sets at the edge sampling the offending byte; cleared only by rstn.
- Back-to-back byte_valid every cycle must be accepted (one byte/cycle).
- frame_rstn asserted mid-burst: writes already committed remain; no partial byte written.

## Configuration
- SPI_REG_READBACK_EN defined: read commands enter RDATA; at the edge accepting the read command (and each subsequent RDATA byte), an 8-bit shifter loads regs[addr]; miso = shifter[7], shifting left one bit per sclk, MSB first; loading past NUM_REGS-1 sets err.
- Undefined: no shifter, miso constant 0, reads go to IGNORE without err.

## Structure
- Package spi_reg_pkg: state enum (CMD, WDATA, RDATA, IGNORE), CMD_WR_BIT = 7, ADDR_W = 7.
- One sub-module: spi_readback_shifter (load, shift, miso), instantiated only under SPI_REG_READBACK_EN.

## Test plan
- rstn pulse → all regs 8'h00, err 0, wr_strobe 0, miso 0.
- Frame 8'h83, 8'hA5, 8'h5A → reg3 = A5, reg4 = 5A, two wr_strobe pulses one cycle after each byte, wr_addr = 4.
- Frame 8'h8F, 8'h11, 8'h22 (NUM_REGS 16) → reg15 = 11, 8'h22 dropped, err = 1.
- Frame 8'h81, 8'h77, frame_rstn pulse, then 8'h82, 8'h99 → reg1 = 77, reg2 = 99, no err.
- Command 8'hC0 (addr 64, NUM_REGS 16) → IGNORE, err = 1, no wr_strobe for following bytes.
- With SPI_REG_READBACK_EN, reg2 = 8'hC3, frame 8'h02 then dummy bytes → miso = 1,1,0,0,0,0,1,1 then bits of reg3.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared constants for the SPI configuration-register controller.
//   ADDR_W      width of the register address carried in a command byte
//   CMD_WR_BIT  command-byte bit selecting write (1) or read (0)
//   ST_*        controller FSM state encodings (CMD, WDATA, RDATA, IGNORE)
package spi_reg_pkg;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned CMD_WR_BIT = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_CMD    = 2'd0;
    localparam state_t ST_WDATA  = 2'd1;
    localparam state_t ST_RDATA  = 2'd2;
    localparam state_t ST_IGNORE = 2'd3;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: byte stream in, register file and status out.
//   byte_in/byte_valid  completed byte from the serial-to-parallel front end
//   regs                flattened register array, reg k at [8k+7:8k]
//   wr_strobe/wr_addr   one-cycle write pulse and address of the last write
//   err                 sticky address-overrun flag
//   miso                readback serial data
// Modports: master drives bytes (front end / bench), slave is the controller.
interface spi_reg_ctrl_if
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
);

    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic [NUM_REGS*8-1:0] regs;
    logic                  wr_strobe;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  err;
    logic                  miso;

    modport master (
        output byte_in,
        output byte_valid,
        input  regs,
        input  wr_strobe,
        input  wr_addr,
        input  err,
        input  miso
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output regs,
        output wr_strobe,
        output wr_addr,
        output err,
        output miso
    );

endinterface

// File: rtl/spi_readback_shifter.sv
// spi_readback_shifter: 8-bit parallel-load, MSB-first shift register for readback.
//   sclk    SPI clock, posedge
//   rstn    asynchronous active-low clear (full reset combined with frame reset)
//   i_load  load i_data this edge instead of shifting
//   i_data  register value to serialise
//   o_miso  current MSB of the shifter
module spi_readback_shifter (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_miso
);

    logic [7:0] r_sh;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_sh <= 8'h00;
        end else if (i_load) begin
            r_sh <= i_data;
        end else begin
            r_sh <= {r_sh[6:0], 1'b0};
        end
    end

    assign o_miso = r_sh[7];

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command decoder and configuration-register file behind the SPI
// serial-to-parallel front end. First byte of a frame is a command (bit7 write,
// bits 6:0 start address); following bytes are written with address auto-increment.
//   sclk        SPI clock, all state on posedge
//   rstn        asynchronous active-low full reset
//   frame_rstn  asynchronous active-low frame abort; resets FSM/address/shifter only
//   bus         spi_reg_ctrl_if.slave (byte stream in, regs/strobe/err/miso out)
// Build option: define SPI_REG_READBACK_EN to enable read commands and miso readback;
// otherwise reads are ignored and miso is tied low.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input logic           sclk,
    input logic           rstn,
    input logic           frame_rstn,
    spi_reg_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [7:0]        r_regs [NUM_REGS];
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_err;
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    // Set when a burst ran off the top of the array; a further byte then flags err.
    logic              r_ovf;

    logic              w_frame_rstn;
    logic              w_accept;
    logic              w_cmd_wr;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_cmd_in_range;
    logic              w_at_last;
    state_t            w_state_d;
    logic [ADDR_W-1:0] w_addr_d;
    logic              w_ovf_d;
    logic              w_wr_en;
    logic              w_err_set;
`ifdef SPI_REG_READBACK_EN
    logic              w_load;
    logic [ADDR_W-1:0] w_load_addr;
    logic [7:0]        w_load_data;
`endif

    // Frame-scoped state is cleared by either reset source.
    assign w_frame_rstn   = rstn & frame_rstn;
    assign w_accept       = bus.byte_valid & frame_rstn;
    assign w_cmd_wr       = bus.byte_in[CMD_WR_BIT];
    assign w_cmd_addr     = bus.byte_in[ADDR_W-1:0];
    assign w_cmd_in_range = ({1'b0, w_cmd_addr} < 8'(NUM_REGS));
    assign w_at_last      = (r_addr == LAST_ADDR);

    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_ovf_d   = r_ovf;
        w_wr_en   = 1'b0;
        w_err_set = 1'b0;
`ifdef SPI_REG_READBACK_EN
        w_load      = 1'b0;
        w_load_addr = w_cmd_addr;
`endif
        if (w_accept) begin
            case (r_state)
                ST_CMD: begin
                    if (!w_cmd_in_range) begin
                        w_err_set = 1'b1;
                        w_state_d = ST_IGNORE;
                    end else if (w_cmd_wr) begin
                        w_state_d = ST_WDATA;
                        w_addr_d  = w_cmd_addr;
                    end else begin
`ifdef SPI_REG_READBACK_EN
                        w_state_d   = ST_RDATA;
                        w_addr_d    = w_cmd_addr;
                        w_load      = 1'b1;
                        w_load_addr = w_cmd_addr;
`else
                        w_state_d = ST_IGNORE;
`endif
                    end
                end
                ST_WDATA: begin
                    w_wr_en = 1'b1;
                    if (w_at_last) begin
                        w_state_d = ST_IGNORE;
                        w_ovf_d   = 1'b1;
                    end else begin
                        w_addr_d = r_addr + 1'b1;
                    end
                end
                ST_RDATA: begin
                    // Incoming byte is a dummy; advance and preload the next register.
                    if (w_at_last) begin
                        w_state_d = ST_IGNORE;
                        w_ovf_d   = 1'b1;
                    end else begin
                        w_addr_d = r_addr + 1'b1;
`ifdef SPI_REG_READBACK_EN
                        w_load      = 1'b1;
                        w_load_addr = r_addr + 1'b1;
`endif
                    end
                end
                default: begin
                    if (r_ovf) begin
                        w_err_set = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge w_frame_rstn) begin
        if (!w_frame_rstn) begin
            r_state <= ST_CMD;
            r_addr  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_addr  <= w_addr_d;
            r_ovf   <= w_ovf_d;
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                r_regs[k] <= RESET_VAL;
            end
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_wr_strobe <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= r_addr;
                for (int k = 0; k < int'(NUM_REGS); k++) begin
                    if (r_addr == ADDR_W'(k)) begin
                        r_regs[k] <= bus.byte_in;
                    end
                end
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_flat
        assign bus.regs[8*k +: 8] = r_regs[k];
    end

    assign bus.wr_strobe = r_wr_strobe;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.err       = r_err;

`ifdef SPI_REG_READBACK_EN
    always_comb begin
        w_load_data = 8'h00;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (w_load_addr == ADDR_W'(k)) begin
                w_load_data = r_regs[k];
            end
        end
    end

    spi_readback_shifter u_shifter (
        .sclk   (sclk),
        .rstn   (w_frame_rstn),
        .i_load (w_load),
        .i_data (w_load_data),
        .o_miso (bus.miso)
    );
`else
    assign bus.miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed self-checking bench for spi_reg_ctrl (NUM_REGS = 16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_spi_reg_ctrl;

    localparam int unsigned NREG = 16;

    logic sclk;
    logic rstn;
    logic frame_rstn;

    spi_reg_ctrl_if #(.NUM_REGS(NREG)) bus ();

    spi_reg_ctrl #(
        .NUM_REGS  (NREG),
        .RESET_VAL (8'h00)
    ) dut (
        .sclk       (sclk),
        .rstn       (rstn),
        .frame_rstn (frame_rstn),
        .bus        (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NREG*8-1:0] exp_regs;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int k);
        return bus.regs[8*k +: 8];
    endfunction

    task automatic drive(input logic [7:0] b);
        @(negedge sclk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge sclk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic frame_pulse();
        @(negedge sclk);
        bus.byte_valid = 1'b0;
        frame_rstn     = 1'b0;
        @(negedge sclk);
        frame_rstn = 1'b1;
    endtask

`ifdef SPI_REG_READBACK_EN
    logic [7:0] rb;
`endif

    initial begin
        rstn           = 1'b0;
        frame_rstn     = 1'b1;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        exp_regs       = '0;
        repeat (2) @(negedge sclk);
        rstn = 1'b1;
        @(negedge sclk);

        // Reset state
        chk("rst_regs", bus.regs, '0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_strobe", bus.wr_strobe, 1'b0);
        chk("rst_wr_addr", bus.wr_addr, 7'd0);
        chk("rst_miso", bus.miso, 1'b0);

        // Burst write 83, A5, 5A back-to-back
        drive(8'h83);
        drive(8'hA5);
        chk("w1_strobe_after_cmd", bus.wr_strobe, 1'b0);
        drive(8'h5A);
        chk("w1_strobe_b1", bus.wr_strobe, 1'b1);
        chk("w1_wr_addr_b1", bus.wr_addr, 7'd3);
        chk("w1_reg3", reg_at(3), 8'hA5);
        idle();
        chk("w1_strobe_b2", bus.wr_strobe, 1'b1);
        chk("w1_wr_addr_b2", bus.wr_addr, 7'd4);
        chk("w1_reg4", reg_at(4), 8'h5A);
        idle();
        chk("w1_strobe_low", bus.wr_strobe, 1'b0);
        exp_regs[8*3 +: 8] = 8'hA5;
        exp_regs[8*4 +: 8] = 8'h5A;
        frame_pulse();

        // Frame abort mid-burst; a byte offered during frame reset is dropped
        drive(8'h81);
        drive(8'h77);
        idle();
        chk("fa_reg1", reg_at(1), 8'h77);
        @(negedge sclk);
        frame_rstn     = 1'b0;
        bus.byte_in    = 8'h85;
        bus.byte_valid = 1'b1;
        @(negedge sclk);
        frame_rstn     = 1'b1;
        bus.byte_valid = 1'b0;
        drive(8'h82);
        drive(8'h99);
        idle();
        chk("fa_reg2", reg_at(2), 8'h99);
        chk("fa_wr_addr", bus.wr_addr, 7'd2);
        chk("fa_err", bus.err, 1'b0);
        exp_regs[8*1 +: 8] = 8'h77;
        exp_regs[8*2 +: 8] = 8'h99;
        chk("fa_regs", bus.regs, exp_regs);
        frame_pulse();

`ifdef SPI_REG_READBACK_EN
        // Readback: reg2 = C3, reg3 = 3C, stream out from address 2
        drive(8'h82);
        drive(8'hC3);
        drive(8'h3C);
        idle();
        frame_pulse();
        exp_regs[8*2 +: 8] = 8'hC3;
        exp_regs[8*3 +: 8] = 8'h3C;
        drive(8'h02);
        idle();
        rb = 8'hC3;
        chk("rb_bit7", bus.miso, rb[7]);
        for (int i = 6; i >= 1; i--) begin
            @(negedge sclk);
            chk("rb_bit", bus.miso, rb[i]);
        end
        @(negedge sclk);
        chk("rb_bit0", bus.miso, rb[0]);
        bus.byte_in    = 8'hFF;
        bus.byte_valid = 1'b1;
        idle();
        rb = 8'h3C;
        chk("rb_next_bit7", bus.miso, rb[7]);
        @(negedge sclk);
        chk("rb_next_bit6", bus.miso, rb[6]);
        chk("rb_err", bus.err, 1'b0);
        frame_pulse();
`else
        // Read command without readback: ignored, no err, miso stays low
        drive(8'h02);
        drive(8'hFF);
        chk("rd_miso", bus.miso, 1'b0);
        drive(8'hFF);
        chk("rd_strobe", bus.wr_strobe, 1'b0);
        idle();
        chk("rd_err", bus.err, 1'b0);
        chk("rd_regs", bus.regs, exp_regs);
        frame_pulse();
`endif

        // Write at the top address, then one byte too many
        drive(8'h8F);
        drive(8'h11);
        drive(8'h22);
        chk("top_strobe", bus.wr_strobe, 1'b1);
        chk("top_reg15", reg_at(15), 8'h11);
        chk("top_err_before", bus.err, 1'b0);
        idle();
        chk("top_err_after", bus.err, 1'b1);
        chk("top_no_strobe", bus.wr_strobe, 1'b0);
        exp_regs[8*15 +: 8] = 8'h11;
        chk("top_regs", bus.regs, exp_regs);
        frame_pulse();
        chk("top_err_sticky", bus.err, 1'b1);

        // Full reset clears everything again
        @(negedge sclk);
        rstn = 1'b0;
        @(negedge sclk);
        rstn = 1'b1;
        chk("rst2_regs", bus.regs, '0);
        chk("rst2_err", bus.err, 1'b0);
        chk("rst2_wr_addr", bus.wr_addr, 7'd0);

        // Out-of-range command address
        drive(8'hC0);
        drive(8'h11);
        chk("oor_err", bus.err, 1'b1);
        drive(8'h22);
        chk("oor_strobe1", bus.wr_strobe, 1'b0);
        idle();
        chk("oor_strobe2", bus.wr_strobe, 1'b0);
        chk("oor_regs", bus.regs, '0);
        frame_pulse();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
